// File: rtl/camera_pkg.sv
// camera_pkg: shared constants and capture-state encoding
// for the OV7670-style byte-stream capture path.
package camera_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W       = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/camera_capture_sync_edge_det.sv
// sync_edge_det: registers a 1-bit input once and flags its
// rising/falling edges against the previous registered value.
// Ports: i_clk, i_rst (async high), i_d in;
//        o_q (registered), o_rise, o_fall out.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_q    <= i_d;
      r_prev <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_prev;
  assign o_fall = ~r_q & r_prev;

endmodule

// File: rtl/camera_capture.sv
// camera_capture: frames the camera byte stream on vsync, pairs
// bytes into RGB565 pixels and issues frame-buffer writes.
// Ports: pclk, rst (async high), en, cam_vsync, cam_href,
//   cam_data[7:0] in; pix_valid, pix_data[15:0],
//   pix_addr[ADDR_W-1:0], frame_done, frame_err, busy out.
module camera_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  import camera_pkg::*;

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [COL_W-1:0] COL_END  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(HEIGHT);
  // one extra bit so a frame that fills 2^ADDR_W exactly
  // can still represent "full"
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(WIDTH * HEIGHT);

  logic w_vs_q;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_hr_q;
  logic w_hr_rise;
  logic w_hr_fall;

  sync_edge_det u_vs (
    .i_clk  (pclk),
    .i_rst  (rst),
    .i_d    (cam_vsync),
    .o_q    (w_vs_q),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det u_hr (
    .i_clk  (pclk),
    .i_rst  (rst),
    .i_d    (cam_href),
    .o_q    (w_hr_q),
    .o_rise (w_hr_rise),
    .o_fall (w_hr_fall)
  );

  logic [7:0]        r_d_q;
  cap_state_t        r_state;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_addr;
  logic              r_pix_valid;
  logic [15:0]       r_pix_data;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_frame_done;
  logic              r_frame_err;
  logic              r_busy;

  logic              w_full;
  logic              w_line_cnt;
  logic [ROW_W-1:0]  w_row_fin;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_d_q <= 8'h00;
    end else begin
      r_d_q <= cam_data;
    end
  end

  assign w_full     = (r_addr == ADDR_END);
  // a line end only counts if the line carried a pixel
  assign w_line_cnt = w_hr_fall && (r_col != '0);

  // row count including a line that ends on this same cycle
  always_comb begin
    w_row_fin = r_row;
    if (w_line_cnt && r_row != ROW_END) begin
      w_row_fin = r_row + ROW_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_hi         <= 8'h00;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= 16'h0000;
      r_pix_addr   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_vs_q) begin
            r_state <= SYNC;
          end
        end
        SYNC: begin
          if (w_vs_fall && en) begin
            r_state     <= ACTIVE;
            r_busy      <= 1'b1;
            r_frame_err <= 1'b0;
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_phase     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (w_hr_rise) begin
            r_col <= '0;
          end
          if (w_hr_q) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_hi <= r_d_q;
            end else if (w_full) begin
              r_frame_err <= 1'b1;
            end else begin
              r_pix_valid <= 1'b1;
              r_pix_data  <= {r_hi, r_d_q};
              r_pix_addr  <= r_addr[ADDR_W-1:0];
              r_addr      <= r_addr + CNT_W'(1);
              // over-long line: flag now, hold col
              if (r_col == COL_END) begin
                r_frame_err <= 1'b1;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end else begin
            r_phase <= 1'b0;
          end
          if (w_hr_fall) begin
            if (r_col != COL_END || r_phase) begin
              r_frame_err <= 1'b1;
            end
            if (w_line_cnt && r_row == ROW_END) begin
              r_frame_err <= 1'b1;
            end
            r_row <= w_row_fin;
            r_col <= '0;
          end
          if (w_vs_rise) begin
            r_state      <= SYNC;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            // short frame, or cut off mid-line
            if (w_row_fin != ROW_END || w_hr_q) begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_addr   = r_pix_addr;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule
